// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one full-subtractor step per clock.
// Define SERSUB_OVERFLOW_EN to add the signed overflow output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERSUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_d;
  logic             bor_nx;
`ifdef SERSUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  assign bit_d  = a_q[0] ^ b_q[0] ^ bor_q;
  assign bor_nx = (~a_q[0] & b_q[0])
                | (~(a_q[0] ^ b_q[0]) & bor_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    bout_d  = bout_q;
`ifdef SERSUB_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bor_d  = bor_nx;
        cnt_d  = cnt_q + 1'b1;
        // Last bit: operand LSBs now hold the original MSBs
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          bout_d  = bor_nx;
`ifdef SERSUB_OVERFLOW_EN
          ovf_d   = (a_q[0] != b_q[0]) & (bit_d != a_q[0]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERSUB_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SERSUB_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Reference: plain integer subtraction of the accepted operands.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERSUB_OVERFLOW_EN
  logic         overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERSUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = (int'(x) - int'(y) + 256) % 256;
    return r[W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int s;
    s = int'($signed(x)) - int'($signed(y));
    return (s > 127) || (s < -128);
  endfunction

  function automatic logic get_ovf();
`ifdef SERSUB_OVERFLOW_EN
    return overflow;
`else
    return 1'b0;
`endif
  endfunction

  // Called #1 after a posedge with the DUT idle; returns #1 after done edge
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output int bcnt,
                       output logic [W-1:0] d, output logic bo,
                       output logic ov);
    start = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    d = diff;
    bo = borrow_out;
    ov = get_ovf();
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] av,
                          input logic [W-1:0] bv);
    int lat, bcnt;
    logic [W-1:0] d;
    logic bo, ov;
    logic [W-1:0] ed;
    logic eb;
    do_op(av, bv, lat, bcnt, d, bo, ov);
    ed = ref_diff(av, bv);
    eb = (av < bv);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL %s latency got=%0d exp=8", nm, lat);
    end
    total++;
    if (bcnt !== 8) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d exp=8", nm, bcnt);
    end
    total++;
    if (d !== ed || bo !== eb) begin
      bad++;
      $display("FAIL %s a=%h b=%h got diff=%h bo=%b exp diff=%h bo=%b",
               nm, av, bv, d, bo, ed, eb);
    end
`ifdef SERSUB_OVERFLOW_EN
    total++;
    if (ov !== ref_ovf(av, bv)) begin
      bad++;
      $display("FAIL %s overflow got=%b exp=%b", nm, ov, ref_ovf(av, bv));
    end
`endif
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width got=%b exp=0", nm, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, diff, borrow_out, get_ovf()} !== '0) begin
      bad++;
      $display("FAIL reset got busy=%b done=%b diff=%h bo=%b exp all 0",
               busy, done, diff, borrow_out);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    check_op("d_05_03", 8'h05, 8'h03);
    check_op("d_03_05", 8'h03, 8'h05);
    check_op("d_00_00", 8'h00, 8'h00);
    check_op("d_80_01", 8'h80, 8'h01);
    check_op("d_7f_ff", 8'h7F, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (diff !== ref_diff(8'h7F, 8'hFF) || borrow_out !== 1'b1) begin
      bad++;
      $display("FAIL hold_idle got diff=%h bo=%b exp diff=%h bo=1",
               diff, borrow_out, ref_diff(8'h7F, 8'hFF));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      check_op("rand", W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    start = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    @(posedge clk);
    #1;
    for (int e = 1; e <= 27; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        hits.push_back(e);
        total++;
        if (diff !== 8'hFE || borrow_out !== 1'b0) begin
          bad++;
          $display("FAIL b2b_result at=%0d got diff=%h bo=%b exp diff=fe bo=0",
                   e, diff, borrow_out);
        end
      end
    end
    start = 1'b0;
    total++;
    if (hits.size() !== 3 || hits[0] !== 8 || hits[1] !== 17 || hits[2] !== 26) begin
      bad++;
      $display("FAIL b2b_timing got n=%0d exp done at edges 8,17,26", hits.size());
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int lat;
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 8 || diff !== 8'h0F || borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start got lat=%0d diff=%h bo=%b exp lat=8 diff=0f bo=0",
               lat, diff, borrow_out);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    int seen;
    start = 1'b1;
    a = 8'h5A;
    b = 8'h33;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got busy=%b done=%b diff=%h bo=%b exp 0,0,00,0",
               busy, done, diff, borrow_out);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL mid_reset_nodone got=%0d pulses exp=0", seen);
    end
    check_op("after_rst", 8'h05, 8'h03);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-006 a  input  WIDTH  minuend; latched when start is accepted.
REQ-007 b  input  WIDTH  subtrahend; latched when start is accepted.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse when diff/borrow_out are valid.
REQ-010 diff  output  WIDTH  result a-b, modulo 2^WIDTH.
REQ-011 borrow_out  output  1  final borrow; high when a<b unsigned.

Function
REQ-012 The block SHALL compute a-b bit-serially, LSB first, one bit per clock, using a full-subtractor stage with a registered borrow.
REQ-013 Per bit: d = ai ^ bi ^ bor; bor_next = (~ai & bi) | (~(ai ^ bi) & bor).
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; encoding at implementer's choice.
REQ-015 IDLE: start=1 at an edge SHALL latch a, b into shift registers, clear borrow and bit counter, go to SHIFT.
REQ-016 SHIFT: each edge SHALL process one bit, shift d into diff from the MSB side, shift operands right, increment counter.
REQ-017 After the WIDTH-th SHIFT edge the FSM SHALL enter DONE; diff and borrow_out SHALL be final at that point.
REQ-018 DONE: done=1 for exactly that one cycle; next edge goes to SHIFT if start=1 (operands latched, back-to-back), else IDLE.
REQ-019 Latency: done SHALL be high in the cycle following the (WIDTH+1)th rising edge counted from, and including, the edge that accepts start.
REQ-020 busy SHALL be 1 exactly in SHIFT; start is accepted only when busy=0.
REQ-021 start during SHIFT SHALL be ignored; the operation in flight completes unchanged and a/b changes have no effect.
REQ-022 diff and borrow_out SHALL hold their last final values in IDLE until the next accepted start.
REQ-023 During SHIFT, diff SHALL be treated as intermediate; its value is undefined to the consumer until done.
REQ-024 Bit counter width SHALL be $clog2(WIDTH)+1; counter SHALL NOT wrap within an operation.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, borrow_out=0, borrow register=0, counter=0, regardless of state.
REQ-026 rst SHALL take priority over start; reset mid-SHIFT aborts the operation with no done pulse.
REQ-027 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro SERSUB_OVERFLOW_EN: when defined, an extra output port overflow (1 bit) SHALL exist and be compiled in.
REQ-029 With SERSUB_OVERFLOW_EN: overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]) (signed two's-complement overflow), updated with diff, reset to 0, held like diff.
REQ-030 Without SERSUB_OVERFLOW_EN: no overflow port or logic; all other behaviour identical.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, start pulse -> done 9 edges after accept, diff=0x02, borrow_out=0, busy high 8 cycles.
REQ-032 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0x00 -> diff=0x00, borrow_out=0.
REQ-033 start held high continuously with a=0xFF, b=0x01 -> repeated ops, done every 9 cycles, diff=0xFE, borrow_out=0 each time.
REQ-034 Accept a=0x10, b=0x01; pulse start with a=0xAA mid-SHIFT -> ignored, result diff=0x0F, borrow_out=0.
REQ-035 rst=1 at 4th SHIFT edge -> next cycle busy=0, done=0, diff=0x00; no done pulse follows.
REQ-036 With SERSUB_OVERFLOW_EN: a=0x80, b=0x01 -> diff=0x7F, overflow=1; a=0x05, b=0x03 -> overflow=0.
